spi_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one SPI master (spigen/spiperi pair) between N requesters. Each requester presents a byte and its SPI mode (cpol/cpha). The block grants one requester at a time and drives the master's start, mode and data inputs. It detects transfer completion from the master's chip-select and returns the received byte with a one-cycle done pulse. A watchdog aborts a transfer that never completes.

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_arb_rr_pick.sv | 35 +++
 rtl/spi_arb.sv | 132 +++++++++++++
 tb/tb_spi_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: sequencer state encoding and mode bit layout.
// Pure constants; no logic and no timing.
package spi_pkg;

  localparam int DEF_DATA_W = 8;

  // Layout of a requester's {cpol,cpha} mode pair
  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_WAIT_LO = 3'd2;
  localparam logic [2:0] ST_BUSY    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

endpackage

// File: rtl/spi_arb_rr_pick.sv
// Round-robin priority selector: the first requester after last_gnt wins (one-hot win plus index).
// Purely combinational; no backpressure of its own.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_gnt,
  output logic [N_REQ-1:0] win,
  output logic [IW-1:0]    win_idx,
  output logic             vld
);

  logic [IW:0] cand;

  always_comb begin
    win     = '0;
    win_idx = '0;
    vld     = 1'b0;
    cand    = '0;
    // Walk N_REQ slots starting just after last_gnt, wrapping back to 0
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, last_gnt} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ)) begin
        cand = cand - (IW+1)'(N_REQ);
      end
      if (!vld && req[cand[IW-1:0]]) begin
        vld               = 1'b1;
        win[cand[IW-1:0]] = 1'b1;
        win_idx           = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/spi_arb.sv
// Shares one SPI master between N_REQ requesters: round-robin grant, start/mode/data drive, done on cs rise.
// Grant 1 cycle after req, m_start 2 cycles after req; requesters hold req until done, watchdog aborts stalls.
module spi_arb
  import spi_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TO_CYC = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*DATA_W-1:0] req_dat,
  input  logic [N_REQ*2-1:0]    req_mode,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic                  err,
  output logic [DATA_W-1:0]     rsp_dat,
  output logic                  m_start,
  output logic                  m_cpol,
  output logic                  m_cpha,
  output logic [DATA_W-1:0]     m_p_dat,
  input  logic                  m_cs,
  input  logic [DATA_W-1:0]     m_rcvd
);

  localparam int IW   = $clog2(N_REQ);
  localparam int WD_W = $clog2(TO_CYC + 1);

  logic [2:0]        state;
  logic [IW-1:0]     last_gnt;
  logic [IW-1:0]     gnt_idx;
  logic [WD_W-1:0]   wd;
  logic [WD_W-1:0]   wd_inc;
  logic              wd_hit;

  logic [N_REQ-1:0]  win;
  logic [IW-1:0]     win_idx;
  logic              pick_vld;
  logic [DATA_W-1:0] sel_dat;
  logic [1:0]        sel_mode;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req      (req),
    .last_gnt (last_gnt),
    .win      (win),
    .win_idx  (win_idx),
    .vld      (pick_vld)
  );

  assign sel_dat  = req_dat[int'(win_idx)*DATA_W +: DATA_W];
  assign sel_mode = req_mode[int'(win_idx)*2 +: 2];

  // Saturating watchdog; the hit fires on the TO_CYC-th cycle spent in the phase
  assign wd_inc = (wd == WD_W'(TO_CYC)) ? wd : wd + 1'b1;
  assign wd_hit = (wd == WD_W'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_gnt <= IW'(N_REQ - 1);
      gnt_idx  <= '0;
      wd       <= '0;
      gnt      <= '0;
      done     <= '0;
      err      <= 1'b0;
      rsp_dat  <= '0;
      m_start  <= 1'b0;
      m_cpol   <= 1'b0;
      m_cpha   <= 1'b0;
      m_p_dat  <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt     <= win;
            gnt_idx <= win_idx;
            m_cpol  <= sel_mode[CPOL_BIT];
            m_cpha  <= sel_mode[CPHA_BIT];
            m_p_dat <= sel_dat;
            state   <= ST_START;
          end
        end
        ST_START: begin
          m_start <= 1'b1;
          wd      <= '0;
          state   <= ST_WAIT_LO;
        end
        ST_WAIT_LO: begin
          if (!m_cs) begin
            m_start <= 1'b0;
            wd      <= '0;
            state   <= ST_BUSY;
          end else if (wd_hit) begin
            m_start <= 1'b0;
            done    <= gnt;
            err     <= 1'b1;
            state   <= ST_DONE;
          end else begin
            wd <= wd_inc;
          end
        end
        ST_BUSY: begin
          if (m_cs) begin
            rsp_dat <= m_rcvd;
            done    <= gnt;
            state   <= ST_DONE;
          end else if (wd_hit) begin
            done  <= gnt;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            wd <= wd_inc;
          end
        end
        ST_DONE: begin
          gnt      <= '0;
          last_gnt <= gnt_idx;
          wd       <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arb.sv
// Directed bench for spi_arb: four requesters, watchdog shortened to 16 cycles, bench plays the SPI master.
module tb_spi_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_dat;
  logic [7:0]  req_mode;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        err;
  logic [7:0]  rsp_dat;
  logic        m_start;
  logic        m_cpol;
  logic        m_cpha;
  logic [7:0]  m_p_dat;
  logic        m_cs;
  logic [7:0]  m_rcvd;

  int vectors     = 0;
  int miscompares = 0;

  spi_arb #(
    .N_REQ  (4),
    .DATA_W (8),
    .TO_CYC (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_dat  (req_dat),
    .req_mode (req_mode),
    .gnt      (gnt),
    .done     (done),
    .err      (err),
    .rsp_dat  (rsp_dat),
    .m_start  (m_start),
    .m_cpol   (m_cpol),
    .m_cpha   (m_cpha),
    .m_p_dat  (m_p_dat),
    .m_cs     (m_cs),
    .m_rcvd   (m_rcvd)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called in the cycle right after grant; plays one master frame and checks the done cycle.
  task automatic xact(input logic [3:0] eg, input logic [7:0] etx, input logic [1:0] emode,
                      input logic [7:0] rx, input int lo_wait, input bit bmod,
                      input logic [3:0] breq, input logic [31:0] bdat, input logic [7:0] bmode);
    check("gnt", gnt, eg);
    check("mode", {m_cpol, m_cpha}, emode);
    check("tx", m_p_dat, etx);
    check("start_at_gnt", m_start, 1'b0);
    tick();
    check("start_hi", m_start, 1'b1);
    repeat (lo_wait) begin
      tick();
      check("start_held", m_start, 1'b1);
    end
    m_cs = 1'b0;
    tick();
    check("start_drop", m_start, 1'b0);
    check("gnt_busy", gnt, eg);
    if (bmod) begin
      req      = breq;
      req_dat  = bdat;
      req_mode = bmode;
    end
    repeat (3) tick();
    check("no_early_done", done, 4'b0000);
    check("tx_hold", m_p_dat, etx);
    check("mode_hold", {m_cpol, m_cpha}, emode);
    m_rcvd = rx;
    m_cs   = 1'b1;
    tick();
    check("done", done, eg);
    check("err_clear", err, 1'b0);
    check("rsp", rsp_dat, rx);
    check("gnt_at_done", gnt, eg);
    tick();
    check("done_pulse", done, 4'b0000);
    check("gnt_release", gnt, 4'b0000);
    check("rsp_held", rsp_dat, rx);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    req = '0; req_dat = '0; req_mode = '0; m_cs = 1'b1; m_rcvd = '0;
    do_reset();
    check("rst_gnt", gnt, 4'b0000);
    check("rst_done", done, 4'b0000);
    check("rst_err", err, 1'b0);
    check("rst_rsp", rsp_dat, 8'h00);
    check("rst_start", m_start, 1'b0);
    check("rst_mode", {m_cpol, m_cpha}, 2'b00);
    check("rst_pdat", m_p_dat, 8'h00);

    // Single request from requester 1, mode 11, byte A5
    req = 4'b0010; req_dat = 32'h0000A500; req_mode = 8'h0C;
    tick();
    xact(4'b0010, 8'hA5, 2'b11, 8'hA5, 2, 1'b0, '0, '0, '0);
    req = 4'b0000;
    tick();
    check("idle_no_gnt", gnt, 4'b0000);

    // All four continuously requesting: order 0,1,2,3,0
    do_reset();
    req = 4'b1111; req_dat = 32'h13121110; req_mode = 8'hE4;
    tick();
    xact(4'b0001, 8'h10, 2'b00, 8'hA0, 0, 1'b0, '0, '0, '0);
    tick();
    xact(4'b0010, 8'h11, 2'b01, 8'hA1, 1, 1'b0, '0, '0, '0);
    tick();
    xact(4'b0100, 8'h12, 2'b10, 8'hA2, 0, 1'b0, '0, '0, '0);
    tick();
    xact(4'b1000, 8'h13, 2'b11, 8'hA3, 0, 1'b0, '0, '0, '0);
    tick();
    xact(4'b0001, 8'h10, 2'b00, 8'hB0, 0, 1'b0, '0, '0, '0);
    req = 4'b0000;

    // Requester 2 rewrites its byte and mode during BUSY; captured values must stand
    req = 4'b0100; req_dat = 32'h003C0000; req_mode = 8'h20;
    tick();
    xact(4'b0100, 8'h3C, 2'b10, 8'h3C, 1, 1'b1, 4'b0100, 32'h00FF0000, 8'h30);
    req = 4'b0000;

    // Master never lowers cs: watchdog abort 16 cycles after WAIT_LO entry
    req = 4'b0011; req_dat = 32'h00006655; req_mode = 8'h09;
    tick();
    check("wd_gnt", gnt, 4'b0001);
    tick();
    check("wd_start", m_start, 1'b1);
    repeat (15) tick();
    check("wd_not_yet", done, 4'b0000);
    check("wd_start_still", m_start, 1'b1);
    tick();
    check("wd_done", done, 4'b0001);
    check("wd_err", err, 1'b1);
    check("wd_rsp_kept", rsp_dat, 8'h3C);
    check("wd_start_drop", m_start, 1'b0);
    req = 4'b0010;
    tick();
    check("wd_err_pulse", err, 1'b0);
    check("wd_gnt_clear", gnt, 4'b0000);
    tick();
    xact(4'b0010, 8'h66, 2'b10, 8'h77, 0, 1'b0, '0, '0, '0);
    req = 4'b0000;

    // Reset while BUSY: everything back to reset values, no done
    req = 4'b0001; req_dat = 32'h000000C7; req_mode = 8'h03;
    tick();
    tick();
    m_cs = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_gnt", gnt, 4'b0000);
    check("mid_rst_done", done, 4'b0000);
    check("mid_rst_start", m_start, 1'b0);
    check("mid_rst_rsp", rsp_dat, 8'h00);
    check("mid_rst_pdat", m_p_dat, 8'h00);
    check("mid_rst_mode", {m_cpol, m_cpha}, 2'b00);
    rst = 1'b0;
    m_cs = 1'b1;
    req = 4'b0001; req_dat = 32'h00000081; req_mode = 8'h01;
    tick();
    xact(4'b0001, 8'h81, 2'b01, 8'h18, 0, 1'b0, '0, '0, '0);
    req = 4'b0000;

    // Requester 1 drops req during BUSY: done still issued, no re-grant
    req = 4'b0010; req_dat = 32'h00004200; req_mode = 8'h00;
    tick();
    xact(4'b0010, 8'h42, 2'b00, 8'h24, 0, 1'b1, 4'b0000, 32'h00004200, 8'h00);
    repeat (3) begin
      tick();
      check("drop_no_regnt", gnt, 4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
